// File: rtl/branch_checkpoint_manager.sv
// Ring of branch checkpoints that selects the oldest mispredicted branch and truncates younger entries.
// Recovery packet and unknown_resolve are registered (1 cycle); alloc_ready drops only when the ring is full.
module branch_checkpoint_manager #(
    parameter int BRANCH_NUM    = 4,
    parameter int AL_IDX_W      = 6,
    parameter int RESOLVE_PORTS = 2,
    parameter int CKPT_W        = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic                              alloc_valid,
    output logic                              alloc_ready,
    input  logic [AL_IDX_W-1:0]               alloc_branch_id,
    input  logic                              alloc_color,
    input  logic                              alloc_has_ds,
    input  logic [CKPT_W-1:0]                 alloc_payload,
    output logic [$clog2(BRANCH_NUM)-1:0]     alloc_slot,
    input  logic [RESOLVE_PORTS-1:0]          resolve_valid,
    input  logic [RESOLVE_PORTS*AL_IDX_W-1:0] resolve_branch_id,
    input  logic [RESOLVE_PORTS-1:0]          resolve_color,
    input  logic [RESOLVE_PORTS-1:0]          resolve_miss,
    output logic                              recover_valid,
    output logic [CKPT_W-1:0]                 recover_payload,
    output logic [AL_IDX_W-1:0]               recover_branch_id_ds,
    output logic                              recover_color_ds,
    output logic [AL_IDX_W-1:0]               recover_youngest_ptr,
    output logic                              recover_global_color,
    output logic [$clog2(BRANCH_NUM):0]       occupancy,
    output logic                              unknown_resolve
);
    localparam int IDX_W = $clog2(BRANCH_NUM);
    localparam int OCC_W = IDX_W + 1;

    logic [IDX_W-1:0]      head_q, head_d, tail_q, tail_d;
    logic [BRANCH_NUM-1:0] live_q, live_d, res_q, res_d;
    logic [BRANCH_NUM-1:0] color_q, color_d, ds_q, ds_d;
    logic [AL_IDX_W-1:0]   id_q [BRANCH_NUM];
    logic [AL_IDX_W-1:0]   id_d [BRANCH_NUM];
    logic [CKPT_W-1:0]     payload_q [BRANCH_NUM];
    logic [CKPT_W-1:0]     payload_d [BRANCH_NUM];

    logic                  rec_valid_q, rec_valid_d;
    logic [CKPT_W-1:0]     rec_payload_q, rec_payload_d;
    logic [AL_IDX_W-1:0]   rec_id_ds_q, rec_id_ds_d;
    logic                  rec_color_ds_q, rec_color_ds_d;
    logic [AL_IDX_W-1:0]   rec_yptr_q, rec_yptr_d;
    logic                  rec_gcolor_q, rec_gcolor_d;
    logic                  unknown_q, unknown_d;

    logic [RESOLVE_PORTS-1:0] port_hit;
    logic [IDX_W-1:0]         port_slot [RESOLVE_PORTS];
    logic                     miss_found;
    logic [IDX_W-1:0]         miss_slot;
    logic [AL_IDX_W-1:0]      miss_id;
    logic                     miss_color;
    logic                     any_miss;
    logic                     alloc_fire;
    logic [OCC_W-1:0]         occ;
    logic [AL_IDX_W-1:0]      ds_id;
    logic                     ds_color;

    function automatic logic is_older(input logic [AL_IDX_W-1:0] id_a, input logic c_a,
                                      input logic [AL_IDX_W-1:0] id_b, input logic c_b);
        return ((c_a == c_b) && (id_a < id_b)) || ((c_a != c_b) && (id_a > id_b));
    endfunction

    always_comb begin
        occ = '0;
        for (int i = 0; i < BRANCH_NUM; i++) begin
            occ = occ + OCC_W'(live_q[i]);
        end
    end

    assign occupancy   = occ;
    assign alloc_ready = (occ < OCC_W'(BRANCH_NUM));
    assign alloc_slot  = tail_q;
    assign any_miss    = |(resolve_valid & resolve_miss);
    assign alloc_fire  = alloc_valid && alloc_ready && !any_miss && !flush;

    // Each port looks up the live slot carrying its (id, colour) tag.
    always_comb begin
        logic found;
        for (int p = 0; p < RESOLVE_PORTS; p++) begin
            found        = 1'b0;
            port_slot[p] = '0;
            for (int i = 0; i < BRANCH_NUM; i++) begin
                if (!found && live_q[i] && (color_q[i] == resolve_color[p]) &&
                    (id_q[i] == resolve_branch_id[p*AL_IDX_W +: AL_IDX_W])) begin
                    found        = 1'b1;
                    port_slot[p] = IDX_W'(i);
                end
            end
            port_hit[p] = found;
        end
    end

    // Oldest matching miss wins; strict comparison keeps the lowest port on ties.
    always_comb begin
        miss_found = 1'b0;
        miss_slot  = '0;
        miss_id    = '0;
        miss_color = 1'b0;
        for (int p = 0; p < RESOLVE_PORTS; p++) begin
            if (resolve_valid[p] && resolve_miss[p] && port_hit[p]) begin
                if (!miss_found || is_older(resolve_branch_id[p*AL_IDX_W +: AL_IDX_W],
                                            resolve_color[p], miss_id, miss_color)) begin
                    miss_found = 1'b1;
                    miss_slot  = port_slot[p];
                    miss_id    = resolve_branch_id[p*AL_IDX_W +: AL_IDX_W];
                    miss_color = resolve_color[p];
                end
            end
        end
    end

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        live_d    = live_q;
        res_d     = res_q;
        color_d   = color_q;
        ds_d      = ds_q;
        id_d      = id_q;
        payload_d = payload_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            live_d = '0;
            res_d  = '0;
        end else begin
            for (int p = 0; p < RESOLVE_PORTS; p++) begin
                if (resolve_valid[p] && !resolve_miss[p] && port_hit[p]) begin
                    res_d[port_slot[p]] = 1'b1;
                end
            end
            if (miss_found) begin
                res_d[miss_slot] = 1'b1;
                // Clearing after the correct resolves discards any that hit squashed slots.
                for (int i = 0; i < BRANCH_NUM; i++) begin
                    if (live_q[i] && is_older(miss_id, miss_color, id_q[i], color_q[i])) begin
                        live_d[i] = 1'b0;
                        res_d[i]  = 1'b0;
                    end
                end
                tail_d = miss_slot + IDX_W'(1);
            end else if (alloc_fire) begin
                live_d[tail_q]    = 1'b1;
                res_d[tail_q]     = 1'b0;
                id_d[tail_q]      = alloc_branch_id;
                color_d[tail_q]   = alloc_color;
                ds_d[tail_q]      = alloc_has_ds;
                payload_d[tail_q] = alloc_payload;
                tail_d            = tail_q + IDX_W'(1);
            end
            if (live_q[head_q] && res_q[head_q]) begin
                live_d[head_q] = 1'b0;
                res_d[head_q]  = 1'b0;
                head_d         = head_q + IDX_W'(1);
            end
        end
    end

    assign ds_id    = id_q[miss_slot] + AL_IDX_W'(ds_q[miss_slot]);
    assign ds_color = color_q[miss_slot] ^ (ds_q[miss_slot] && (ds_id == '0));

    always_comb begin
        rec_valid_d    = miss_found && !flush;
        rec_payload_d  = rec_payload_q;
        rec_id_ds_d    = rec_id_ds_q;
        rec_color_ds_d = rec_color_ds_q;
        rec_yptr_d     = rec_yptr_q;
        rec_gcolor_d   = rec_gcolor_q;
        if (rec_valid_d) begin
            rec_payload_d  = payload_q[miss_slot];
            rec_id_ds_d    = ds_id;
            rec_color_ds_d = ds_color;
            rec_yptr_d     = ds_id + AL_IDX_W'(1);
            rec_gcolor_d   = ds_color ^ (ds_id == {AL_IDX_W{1'b1}});
        end
        unknown_d = |(resolve_valid & ~port_hit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q         <= '0;
            tail_q         <= '0;
            live_q         <= '0;
            res_q          <= '0;
            color_q        <= '0;
            ds_q           <= '0;
            for (int i = 0; i < BRANCH_NUM; i++) begin
                id_q[i]      <= '0;
                payload_q[i] <= '0;
            end
            rec_valid_q    <= 1'b0;
            rec_payload_q  <= '0;
            rec_id_ds_q    <= '0;
            rec_color_ds_q <= 1'b0;
            rec_yptr_q     <= '0;
            rec_gcolor_q   <= 1'b0;
            unknown_q      <= 1'b0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            live_q         <= live_d;
            res_q          <= res_d;
            color_q        <= color_d;
            ds_q           <= ds_d;
            id_q           <= id_d;
            payload_q      <= payload_d;
            rec_valid_q    <= rec_valid_d;
            rec_payload_q  <= rec_payload_d;
            rec_id_ds_q    <= rec_id_ds_d;
            rec_color_ds_q <= rec_color_ds_d;
            rec_yptr_q     <= rec_yptr_d;
            rec_gcolor_q   <= rec_gcolor_d;
            unknown_q      <= unknown_d;
        end
    end

    assign recover_valid        = rec_valid_q;
    assign recover_payload      = rec_payload_q;
    assign recover_branch_id_ds = rec_id_ds_q;
    assign recover_color_ds     = rec_color_ds_q;
    assign recover_youngest_ptr = rec_yptr_q;
    assign recover_global_color = rec_gcolor_q;
    assign unknown_resolve      = unknown_q;

endmodule

// File: tb/tb_branch_checkpoint_manager.sv
// Directed vector table plus randomized traffic against a queue-based checkpoint model.
module tb_branch_checkpoint_manager;
    localparam int N  = 4;
    localparam int AW = 6;
    localparam int RP = 2;
    localparam int CW = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            alloc_valid = 1'b0;
    logic            alloc_ready;
    logic [AW-1:0]   alloc_branch_id = '0;
    logic            alloc_color = 1'b0;
    logic            alloc_has_ds = 1'b0;
    logic [CW-1:0]   alloc_payload = '0;
    logic [1:0]      alloc_slot;
    logic [RP-1:0]   resolve_valid = '0;
    logic [RP*AW-1:0] resolve_branch_id = '0;
    logic [RP-1:0]   resolve_color = '0;
    logic [RP-1:0]   resolve_miss = '0;
    logic            recover_valid;
    logic [CW-1:0]   recover_payload;
    logic [AW-1:0]   recover_branch_id_ds;
    logic            recover_color_ds;
    logic [AW-1:0]   recover_youngest_ptr;
    logic            recover_global_color;
    logic [2:0]      occupancy;
    logic            unknown_resolve;

    always #5 clk = ~clk;

    branch_checkpoint_manager #(.BRANCH_NUM(N), .AL_IDX_W(AW), .RESOLVE_PORTS(RP), .CKPT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_branch_id(alloc_branch_id),
        .alloc_color(alloc_color), .alloc_has_ds(alloc_has_ds), .alloc_payload(alloc_payload),
        .alloc_slot(alloc_slot), .resolve_valid(resolve_valid), .resolve_branch_id(resolve_branch_id),
        .resolve_color(resolve_color), .resolve_miss(resolve_miss), .recover_valid(recover_valid),
        .recover_payload(recover_payload), .recover_branch_id_ds(recover_branch_id_ds),
        .recover_color_ds(recover_color_ds), .recover_youngest_ptr(recover_youngest_ptr),
        .recover_global_color(recover_global_color), .occupancy(occupancy),
        .unknown_resolve(unknown_resolve)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: live checkpoints kept oldest-first in a queue.
    typedef struct {
        int            slot;
        logic [AW-1:0] id;
        logic          c;
        logic          ds;
        logic [CW-1:0] pay;
        bit            res;
    } ck_t;

    ck_t           mq[$];
    int            m_tail = 0;
    bit            m_alloc_acc;
    logic          e_rv = 1'b0, e_unk = 1'b0, e_cds = 1'b0, e_gc = 1'b0;
    logic [AW-1:0] e_dsid = '0, e_yp = '0;
    logic [CW-1:0] e_pay = '0;

    function automatic bit age_older(input logic [AW-1:0] ida, input logic ca,
                                     input logic [AW-1:0] idb, input logic cb);
        return ((ca == cb) && (ida < idb)) || ((ca != cb) && (ida > idb));
    endfunction

    function automatic logic [AW-1:0] rid(input int p);
        return resolve_branch_id[p*AW +: AW];
    endfunction

    task automatic model_reset();
        mq.delete();
        m_tail = 0;
        e_rv = 0; e_unk = 0; e_cds = 0; e_gc = 0;
        e_dsid = '0; e_yp = '0; e_pay = '0;
    endtask

    task automatic model_step();
        int   hit [RP];
        int   best;
        bit   retire;
        bit   anymiss;
        ck_t  mk;
        logic [6:0] s, y;
        for (int p = 0; p < RP; p++) begin
            hit[p] = -1;
            for (int k = 0; k < mq.size(); k++)
                if (hit[p] < 0 && mq[k].id == rid(p) && mq[k].c == resolve_color[p]) hit[p] = k;
        end
        e_unk = 0;
        for (int p = 0; p < RP; p++) if (resolve_valid[p] && hit[p] < 0) e_unk = 1;
        retire  = (mq.size() > 0) && mq[0].res;
        anymiss = |(resolve_valid & resolve_miss);
        best = -1;
        for (int p = 0; p < RP; p++)
            if (resolve_valid[p] && resolve_miss[p] && hit[p] >= 0)
                if (best < 0 || age_older(rid(p), resolve_color[p], rid(best), resolve_color[best])) best = p;
        m_alloc_acc = 0;
        if (flush) begin
            mq.delete();
            m_tail = 0;
            e_rv = 0;
        end else begin
            for (int p = 0; p < RP; p++)
                if (resolve_valid[p] && !resolve_miss[p] && hit[p] >= 0) mq[hit[p]].res = 1;
            if (best >= 0) begin
                mq[hit[best]].res = 1;
                mk = mq[hit[best]];
                for (int j = mq.size() - 1; j >= 0; j--)
                    if (age_older(mk.id, mk.c, mq[j].id, mq[j].c)) mq.delete(j);
                m_tail = (mk.slot + 1) % N;
                s = {mk.c, mk.id} + 7'(mk.ds);
                y = s + 7'd1;
                e_rv = 1; e_pay = mk.pay; e_dsid = s[5:0]; e_cds = s[6]; e_yp = y[5:0]; e_gc = y[6];
            end else begin
                e_rv = 0;
                if (alloc_valid && mq.size() < N && !anymiss) begin
                    mq.push_back('{slot: m_tail, id: alloc_branch_id, c: alloc_color,
                                   ds: alloc_has_ds, pay: alloc_payload, res: 0});
                    m_tail = (m_tail + 1) % N;
                    m_alloc_acc = 1;
                end
            end
            if (retire) void'(mq.pop_front());
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("occupancy",    occupancy, mq.size());
        chk("alloc_ready",  alloc_ready, mq.size() < N);
        chk("alloc_slot",   alloc_slot, m_tail);
        chk("recover_valid", recover_valid, e_rv);
        chk("unknown_resolve", unknown_resolve, e_unk);
        chk("recover_payload", recover_payload, e_pay);
        chk("recover_id_ds", recover_branch_id_ds, e_dsid);
        chk("recover_color_ds", recover_color_ds, e_cds);
        chk("recover_yptr", recover_youngest_ptr, e_yp);
        chk("recover_gcolor", recover_global_color, e_gc);
    endtask

    typedef struct {
        logic fl; logic av; logic [5:0] aid; logic ac; logic ads;
        logic v0; logic [5:0] id0; logic c0; logic m0;
        logic v1; logic [5:0] id1; logic c1; logic m1;
        int occ; logic rdy; int slot; logic rec; logic [5:0] dsid; logic [5:0] yp; logic unk;
    } vec_t;

    function automatic vec_t V(input logic fl, av, input logic [5:0] aid, input logic ac, ads,
                               input logic v0, input logic [5:0] id0, input logic c0, m0,
                               input logic v1, input logic [5:0] id1, input logic c1, m1,
                               input int occ, input logic rdy, input int slot, input logic rec,
                               input logic [5:0] dsid, input logic [5:0] yp, input logic unk);
        vec_t v;
        v.fl = fl; v.av = av; v.aid = aid; v.ac = ac; v.ads = ads;
        v.v0 = v0; v.id0 = id0; v.c0 = c0; v.m0 = m0;
        v.v1 = v1; v.id1 = id1; v.c1 = c1; v.m1 = m1;
        v.occ = occ; v.rdy = rdy; v.slot = slot; v.rec = rec; v.dsid = dsid; v.yp = yp; v.unk = unk;
        return v;
    endfunction

    task automatic drive_idle();
        flush = 0; alloc_valid = 0; resolve_valid = '0; resolve_miss = '0;
    endtask

    vec_t       tv[$];
    logic [6:0] seq;
    logic [6:0] head_seq;

    initial begin
        // Hand-derived vectors: fill/full, miss, dual miss, colour wrap, delay slot, retire, flush.
        tv.push_back(V(0,1, 3,0,0, 0, 0,0,0, 0, 0,0,0, 1,1,1,0, 0,0,0));
        tv.push_back(V(0,1, 7,0,0, 0, 0,0,0, 0, 0,0,0, 2,1,2,0, 0,0,0));
        tv.push_back(V(0,1,10,0,0, 0, 0,0,0, 0, 0,0,0, 3,1,3,0, 0,0,0));
        tv.push_back(V(0,1,12,0,0, 0, 0,0,0, 0, 0,0,0, 4,0,0,0, 0,0,0));
        tv.push_back(V(0,1,20,0,0, 0, 0,0,0, 0, 0,0,0, 4,0,0,0, 0,0,0));
        tv.push_back(V(0,0, 0,0,0, 1, 7,0,1, 0, 0,0,0, 2,1,2,1, 7,8,0));
        tv.push_back(V(0,0, 0,0,0, 0, 0,0,0, 0, 0,0,0, 2,1,2,0, 7,8,0));
        tv.push_back(V(0,0, 0,0,0, 1, 3,0,0, 0, 0,0,0, 2,1,2,0, 7,8,0));
        tv.push_back(V(0,0, 0,0,0, 0, 0,0,0, 0, 0,0,0, 1,1,2,0, 7,8,0));
        tv.push_back(V(0,0, 0,0,0, 0, 0,0,0, 0, 0,0,0, 0,1,2,0, 7,8,0));
        tv.push_back(V(0,1, 3,0,0, 0, 0,0,0, 0, 0,0,0, 1,1,3,0, 7,8,0));
        tv.push_back(V(0,1, 7,0,0, 0, 0,0,0, 0, 0,0,0, 2,1,0,0, 7,8,0));
        tv.push_back(V(0,1,10,0,0, 0, 0,0,0, 0, 0,0,0, 3,1,1,0, 7,8,0));
        tv.push_back(V(0,1,12,0,0, 0, 0,0,0, 0, 0,0,0, 4,0,2,0, 7,8,0));
        tv.push_back(V(0,0, 0,0,0, 1,12,0,1, 1, 7,0,1, 2,1,0,1, 7,8,0));
        tv.push_back(V(0,0, 0,0,0, 1,10,0,0, 0, 0,0,0, 2,1,0,0, 7,8,1));
        tv.push_back(V(0,0, 0,0,0, 0, 0,0,0, 0, 0,0,0, 2,1,0,0, 7,8,0));
        tv.push_back(V(0,0, 0,0,0, 1, 3,0,0, 0, 0,0,0, 2,1,0,0, 7,8,0));
        tv.push_back(V(0,0, 0,0,0, 0, 0,0,0, 0, 0,0,0, 1,1,0,0, 7,8,0));
        tv.push_back(V(0,0, 0,0,0, 0, 0,0,0, 0, 0,0,0, 0,1,0,0, 7,8,0));
        tv.push_back(V(0,1,60,0,0, 0, 0,0,0, 0, 0,0,0, 1,1,1,0, 7,8,0));
        tv.push_back(V(0,1, 2,1,0, 0, 0,0,0, 0, 0,0,0, 2,1,2,0, 7,8,0));
        tv.push_back(V(0,0, 0,0,0, 1,60,0,1, 1, 2,1,0, 1,1,1,1,60,61,0));
        tv.push_back(V(0,0, 0,0,0, 0, 0,0,0, 0, 0,0,0, 0,1,1,0,60,61,0));
        tv.push_back(V(0,1,63,0,1, 0, 0,0,0, 0, 0,0,0, 1,1,2,0,60,61,0));
        tv.push_back(V(0,0, 0,0,0, 1,63,0,1, 0, 0,0,0, 1,1,2,1, 0,1,0));
        tv.push_back(V(0,0, 0,0,0, 0, 0,0,0, 0, 0,0,0, 0,1,2,0, 0,1,0));
        tv.push_back(V(0,1, 3,0,0, 0, 0,0,0, 0, 0,0,0, 1,1,3,0, 0,1,0));
        tv.push_back(V(0,1, 7,0,0, 0, 0,0,0, 0, 0,0,0, 2,1,0,0, 0,1,0));
        tv.push_back(V(0,1,10,0,0, 0, 0,0,0, 0, 0,0,0, 3,1,1,0, 0,1,0));
        tv.push_back(V(0,0, 0,0,0, 1,10,0,0, 1, 7,0,0, 3,1,1,0, 0,1,0));
        tv.push_back(V(0,0, 0,0,0, 1, 3,0,0, 0, 0,0,0, 3,1,1,0, 0,1,0));
        tv.push_back(V(0,0, 0,0,0, 0, 0,0,0, 0, 0,0,0, 2,1,1,0, 0,1,0));
        tv.push_back(V(0,0, 0,0,0, 0, 0,0,0, 0, 0,0,0, 1,1,1,0, 0,1,0));
        tv.push_back(V(0,0, 0,0,0, 0, 0,0,0, 0, 0,0,0, 0,1,1,0, 0,1,0));
        tv.push_back(V(0,1,40,0,0, 0, 0,0,0, 0, 0,0,0, 1,1,2,0, 0,1,0));
        tv.push_back(V(0,1,41,0,0, 0, 0,0,0, 0, 0,0,0, 2,1,3,0, 0,1,0));
        tv.push_back(V(1,0, 0,0,0, 1,41,0,1, 0, 0,0,0, 0,1,0,0, 0,1,0));
        tv.push_back(V(0,0, 0,0,0, 1,40,0,0, 0, 0,0,0, 0,1,0,0, 0,1,1));
        tv.push_back(V(0,0, 0,0,0, 0, 0,0,0, 0, 0,0,0, 0,1,0,0, 0,1,0));

        #12;
        chk("rst occupancy", occupancy, 0);
        chk("rst alloc_ready", alloc_ready, 1);
        chk("rst alloc_slot", alloc_slot, 0);
        chk("rst recover_valid", recover_valid, 0);
        chk("rst recover_payload", recover_payload, 0);
        chk("rst recover_yptr", recover_youngest_ptr, 0);
        chk("rst unknown", unknown_resolve, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;

        foreach (tv[i]) begin
            flush = tv[i].fl;
            alloc_valid = tv[i].av; alloc_branch_id = tv[i].aid; alloc_color = tv[i].ac;
            alloc_has_ds = tv[i].ads; alloc_payload = {$urandom, $urandom};
            resolve_valid = {tv[i].v1, tv[i].v0};
            resolve_branch_id = {tv[i].id1, tv[i].id0};
            resolve_color = {tv[i].c1, tv[i].c0};
            resolve_miss = {tv[i].m1, tv[i].m0};
            cycle();
            chk($sformatf("vec%0d occupancy", i), occupancy, tv[i].occ);
            chk($sformatf("vec%0d alloc_ready", i), alloc_ready, tv[i].rdy);
            chk($sformatf("vec%0d alloc_slot", i), alloc_slot, tv[i].slot);
            chk($sformatf("vec%0d recover_valid", i), recover_valid, tv[i].rec);
            chk($sformatf("vec%0d recover_id_ds", i), recover_branch_id_ds, tv[i].dsid);
            chk($sformatf("vec%0d recover_yptr", i), recover_youngest_ptr, tv[i].yp);
            chk($sformatf("vec%0d unknown", i), unknown_resolve, tv[i].unk);
        end

        // Reset in the middle of a recovery pulse.
        drive_idle();
        alloc_valid = 1; alloc_branch_id = 6'd5; alloc_color = 0; alloc_has_ds = 0;
        alloc_payload = 64'hDEAD_BEEF_0000_0005;
        cycle();
        drive_idle();
        resolve_valid = 2'b01; resolve_branch_id = {6'd0, 6'd5}; resolve_color = 2'b00; resolve_miss = 2'b01;
        cycle();
        chk("midrec recover_valid", recover_valid, 1);
        chk("midrec payload", recover_payload, 64'hDEAD_BEEF_0000_0005);
        drive_idle();
        rst_n = 0;
        #1;
        chk("midrec rst recover_valid", recover_valid, 0);
        chk("midrec rst occupancy", occupancy, 0);
        chk("midrec rst id_ds", recover_branch_id_ds, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;

        seq = '0;
        for (int n = 0; n < 3000; n++) begin
            head_seq = (mq.size() > 0) ? {mq[0].c, mq[0].id} : seq;
            flush = ($urandom_range(0, 99) < 3);
            // Keep live ids within half the colour space so the age rule stays meaningful.
            alloc_valid = ($urandom_range(0, 99) < 60) && (7'(seq - head_seq) < 7'd40);
            alloc_has_ds = ($urandom_range(0, 3) == 0);
            {alloc_color, alloc_branch_id} = seq;
            alloc_payload = {$urandom, $urandom};
            for (int p = 0; p < RP; p++) begin
                resolve_valid[p] = $urandom_range(0, 1) == 1;
                resolve_miss[p]  = $urandom_range(0, 99) < 20;
                if (mq.size() > 0 && $urandom_range(0, 9) < 8) begin
                    int k;
                    k = $urandom_range(0, mq.size() - 1);
                    resolve_branch_id[p*AW +: AW] = mq[k].id;
                    resolve_color[p] = mq[k].c;
                end else begin
                    resolve_branch_id[p*AW +: AW] = 6'($urandom);
                    resolve_color[p] = 1'($urandom);
                end
            end
            cycle();
            if (m_alloc_acc) seq = seq + 7'd1 + 7'(alloc_has_ds) + 7'($urandom_range(0, 2));
        end

        drive_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
